cm0_acg_ctrl: RTL and testbench
===============================

CM0_ACG_CTRL -- requirements
Module: cm0_acg_ctrl

Interface
REQ-001 Parameter ACG, default 1, meaning: 1 = architectural clock gating active; 0 = ENABLE held high permanently.
REQ-002 Parameter IDLE_CYCLES, default 4, meaning: consecutive idle cycles required before gating; legal range 1..15.
REQ-003 Parameter WAKE_CYCLES, default 2, meaning: cycles of ungated clock before WAKE_ACK; legal range 1..15.
REQ-004 CLKIN  input  1  free-running clock; one clock; reset is synchronous and active-high.
REQ-005 RESET  input  1  synchronous active-high reset, sampled on rising CLKIN.
REQ-006 SE  input  1  scan enable; forces ENABLE high.
REQ-007 BUSY  input  1  gated domain has work pending or in flight.
REQ-008 WAKE_REQ  input  1  external wake request, level, held until WAKE_ACK.
REQ-009 CNT_CLR  input  1  clears GATE_CNT.
REQ-010 ENABLE  output  1  clock-enable to downstream clock-gate cell (cm0_acg ENABLE).
REQ-011 GATED  output  1  high while the domain clock is gated.
REQ-012 WAKE_ACK  output  1  one-cycle pulse: gated domain clock is running and stable.
REQ-013 GATE_CNT  output  16  saturating count of cycles spent in GATED.

Function
REQ-014 FSM states RUN, DRAIN, GATED, WAKE; 4-bit down-counter CNT shared by DRAIN and WAKE.
REQ-015 RUN: if BUSY=0 and WAKE_REQ=0 -> DRAIN, CNT loaded IDLE_CYCLES-1; else stay RUN.
REQ-016 DRAIN: BUSY=1 or WAKE_REQ=1 -> RUN; else CNT=0 -> GATED; else CNT decrements.
REQ-017 GATED: BUSY=1 or WAKE_REQ=1 -> WAKE, CNT loaded WAKE_CYCLES-1; else stay GATED.
REQ-018 WAKE: CNT=0 -> RUN; else CNT decrements; BUSY/WAKE_REQ changes ignored during WAKE.
REQ-019 ENABLE driven from a flop whose D is (next state != GATED), ORed with SE; no other combinational path to ENABLE.
REQ-020 ENABLE is low exactly in cycles where state=GATED and SE=0; falls on the same edge state enters GATED, rises on the same edge state leaves GATED.
REQ-021 Total idle latency: BUSY low from cycle n (WAKE_REQ low) -> ENABLE low from cycle n+IDLE_CYCLES+1.
REQ-022 WAKE_ACK registered; high for exactly the first RUN cycle after WAKE; never high otherwise.
REQ-023 WAKE_REQ asserted while in RUN or DRAIN -> WAKE_ACK pulse on next cycle (clock already running), state RUN.
REQ-024 GATED = registered (state==GATED); equals ~ENABLE when SE=0.
REQ-025 GATE_CNT increments by 1 each cycle state=GATED, saturates at 0xFFFF, no wrap.
REQ-026 CNT_CLR has priority over increment: GATE_CNT=0 next cycle.
REQ-027 SE does not alter FSM, CNT or GATE_CNT; only ENABLE.
REQ-028 ACG=0: state held RUN, ENABLE=1, GATED=0, GATE_CNT=0, WAKE_ACK pulses per REQ-023.

Reset
REQ-029 RESET=1 -> state RUN, CNT=0, ENABLE=1, GATED=0, WAKE_ACK=0, GATE_CNT=0 on next rising CLKIN.
REQ-030 RESET mid-DRAIN/GATED/WAKE aborts sequence; ENABLE high the cycle after reset sampled; no WAKE_ACK issued for the aborted wake.

Structure
REQ-031 State encodings (2-bit) and CNT width constant shall live in shared package cm0_acg_pkg.
REQ-032 Saturating GATE_CNT shall be sub-module cm0_acg_satcnt (inputs inc, clr; 16-bit output).
REQ-033 All state flops clocked by ungated CLKIN; no latches.

Verification
REQ-034 Defaults, BUSY 1->0 at cycle 10, held low -> ENABLE low from cycle 15, GATED=1, GATE_CNT counting from 1.
REQ-035 BUSY low cycles 10-12, high at 13 -> state returns RUN, ENABLE never low, GATE_CNT=0.
REQ-036 Gated, WAKE_REQ high at cycle 30 -> ENABLE high cycle 31, WAKE_ACK pulse cycle 33 only, state RUN.
REQ-037 Gated 70000 cycles -> GATE_CNT=0xFFFF held; CNT_CLR pulse -> 0 next cycle, then resumes at 1.
REQ-038 Gated, SE=1 for 5 cycles -> ENABLE=1 those cycles, GATED stays 1, GATE_CNT keeps incrementing.
REQ-039 RESET pulsed in WAKE cycle 1 -> ENABLE=1, state RUN, WAKE_ACK never asserted; ACG=0 build: ENABLE constant 1 across all above.

Source files
------------

// File: rtl/cm0_acg_pkg.sv
// Shared types and constants for the architectural clock-gating controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: the 2-bit FSM state encoding, the width of the shared DRAIN/WAKE
// down-counter, the width of the gated-cycle statistics counter, and a
// helper that turns a cycle count into a down-counter load value.
package cm0_acg_pkg;

    localparam int CNT_W  = 4;   // DRAIN/WAKE down-counter, holds 0..15
    localparam int GCNT_W = 16;  // saturating gated-cycle counter

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_DRAIN = 2'b01,
        ST_GATED = 2'b10,
        ST_WAKE  = 2'b11
    } acg_state_t;

    // The counter is loaded with N-1 and the transition fires on the cycle
    // it reads zero, so the state lasts exactly N cycles.
    function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/cm0_acg_ctrl_if.sv
// Control/status bundle between the gated-domain logic and the clock-gate controller.
// Latency: n/a (wires only).
// Backpressure: WAKE_REQ is a level held until WAKE_ACK; there is no other flow control.
//
// master: the gated-domain side (drives SE, BUSY, WAKE_REQ, CNT_CLR).
// slave : the controller (drives ENABLE, GATED, WAKE_ACK, GATE_CNT).
interface cm0_acg_ctrl_if;

    logic                            SE;        // scan enable, forces ENABLE high
    logic                            BUSY;      // gated domain has work pending
    logic                            WAKE_REQ;  // external wake request (level)
    logic                            CNT_CLR;   // clears GATE_CNT
    logic                            ENABLE;    // clock enable to the gate cell
    logic                            GATED;     // domain clock currently gated
    logic                            WAKE_ACK;  // one-cycle pulse, clock running
    logic [cm0_acg_pkg::GCNT_W-1:0]  GATE_CNT;  // cycles spent gated, saturating

    modport master (
        output SE, BUSY, WAKE_REQ, CNT_CLR,
        input  ENABLE, GATED, WAKE_ACK, GATE_CNT
    );

    modport slave (
        input  SE, BUSY, WAKE_REQ, CNT_CLR,
        output ENABLE, GATED, WAKE_ACK, GATE_CNT
    );

endinterface

// File: rtl/cm0_acg_satcnt.sv
// Saturating up-counter of cycles spent with the domain clock gated.
// Latency: 1 cycle from i_inc/i_clr to o_cnt.
// Backpressure: none; holds at all-ones instead of wrapping.
//
// Ports: i_clk, i_rst (sync, active high), i_inc (count this cycle),
//        i_clr (zero next cycle, wins over i_inc), o_cnt (count value).
module cm0_acg_satcnt
    import cm0_acg_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_inc,
    input  logic              i_clr,
    output logic [GCNT_W-1:0] o_cnt
);

    logic [GCNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + GCNT_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/cm0_acg_ctrl.sv
// Architectural clock-gating controller: gates an idle domain, wakes it on demand.
// Latency: ENABLE falls IDLE_CYCLES+1 cycles after BUSY drops; WAKE_ACK WAKE_CYCLES+1 cycles after a wake from gated.
// Backpressure: WAKE_REQ is held by the requester until the single-cycle WAKE_ACK.
//
// Ports: CLKIN (free-running clock), RESET (sync, active high),
//        bus (slave side of cm0_acg_ctrl_if: SE/BUSY/WAKE_REQ/CNT_CLR in,
//        ENABLE/GATED/WAKE_ACK/GATE_CNT out).
module cm0_acg_ctrl
    import cm0_acg_pkg::*;
#(
    parameter int ACG         = 1,  // 0: clock never gated
    parameter int IDLE_CYCLES = 4,  // 1..15
    parameter int WAKE_CYCLES = 2   // 1..15
) (
    input  logic           CLKIN,
    input  logic           RESET,
    cm0_acg_ctrl_if.slave  bus
);

    acg_state_t       r_state;
    acg_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_en;
    logic             r_gated;
    logic             r_wake_ack;
    logic             r_req_acked;  // current WAKE_REQ level already acknowledged
    logic             w_wake_any;
    logic             w_ack_wake;
    logic             w_ack_run;

    assign w_wake_any = bus.BUSY | bus.WAKE_REQ;

    // Next-state / counter logic. CNT is shared: DRAIN counts idle cycles,
    // WAKE counts ungated settle cycles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_RUN: begin
                if (!w_wake_any) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = cnt_load(IDLE_CYCLES);
                end
            end
            ST_DRAIN: begin
                if (w_wake_any) begin
                    w_state_nxt = ST_RUN;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_GATED;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_GATED: begin
                if (w_wake_any) begin
                    w_state_nxt = ST_WAKE;
                    w_cnt_nxt   = cnt_load(WAKE_CYCLES);
                end
            end
            ST_WAKE: begin
                // Inputs are ignored here: the wake always runs to completion.
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase
        if (ACG == 0) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = '0;
        end
    end

    // Wake from gated acknowledges on the first RUN cycle regardless of
    // cause; a request seen while the clock is already running is
    // acknowledged on the next cycle, once per request level.
    assign w_ack_wake = (r_state == ST_WAKE) && (w_state_nxt == ST_RUN);
    assign w_ack_run  = ((r_state == ST_RUN) || (r_state == ST_DRAIN)) &&
                        bus.WAKE_REQ && !r_req_acked;

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_en        <= 1'b1;
            r_gated     <= 1'b0;
            r_wake_ack  <= 1'b0;
            r_req_acked <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            // Decoded from next state so ENABLE/GATED change on the same
            // edge as the state itself.
            r_en        <= (w_state_nxt != ST_GATED);
            r_gated     <= (w_state_nxt == ST_GATED);
            r_wake_ack  <= w_ack_wake | w_ack_run;
            r_req_acked <= bus.WAKE_REQ & (r_req_acked | w_ack_wake | w_ack_run);
        end
    end

    cm0_acg_satcnt u_satcnt (
        .i_clk (CLKIN),
        .i_rst (RESET),
        .i_inc (r_state == ST_GATED),
        .i_clr (bus.CNT_CLR),
        .o_cnt (bus.GATE_CNT)
    );

    // Scan only overrides the enable; FSM and counters are unaffected.
    assign bus.ENABLE   = r_en | bus.SE;
    assign bus.GATED    = r_gated;
    assign bus.WAKE_ACK = r_wake_ack;

endmodule

// File: tb/tb_cm0_acg_ctrl.sv
// Testbench for cm0_acg_ctrl: a gating build and an ACG=0 build driven in lockstep.
// Latency: n/a.
// Backpressure: n/a.
module tb_cm0_acg_ctrl;

    localparam int IDLE = 4;
    localparam int WAKE = 2;

    logic clk = 1'b0;
    logic rst, b, wr, cc, se;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_no  = 0;

    cm0_acg_ctrl_if if1();
    cm0_acg_ctrl_if if0();

    assign if1.SE = se;  assign if1.BUSY = b;  assign if1.WAKE_REQ = wr;  assign if1.CNT_CLR = cc;
    assign if0.SE = se;  assign if0.BUSY = b;  assign if0.WAKE_REQ = wr;  assign if0.CNT_CLR = cc;

    cm0_acg_ctrl #(.ACG(1), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut1 (
        .CLKIN (clk), .RESET (rst), .bus (if1)
    );
    cm0_acg_ctrl #(.ACG(0), .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)) dut0 (
        .CLKIN (clk), .RESET (rst), .bus (if0)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc_no);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // Reference model. The domain is either gated, waking (cycles left), or
    // running with a streak of consecutive idle cycles; it gates after
    // IDLE+1 idle cycles and runs again after WAKE settle cycles.
    bit m_gated, m_ack, m_acked;
    int m_streak, m_wake_left, m_gcnt;
    bit m0_ack, m0_acked;

    logic last_en, last_ack;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_no, act, exp);
        end
    endtask

    task automatic model_reset();
        m_gated = 0; m_ack = 0; m_acked = 0;
        m_streak = 0; m_wake_left = 0; m_gcnt = 0;
        m0_ack = 0; m0_acked = 0;
    endtask

    task automatic model_step(input bit bi, input bit wri, input bit cci, input bit rsti);
        bit ack_now;
        bit ack0;
        if (rsti) begin
            model_reset();
            return;
        end
        if (cci)                              m_gcnt = 0;
        else if (m_gated && m_gcnt < 65535)   m_gcnt = m_gcnt + 1;
        ack_now = 0;
        if (m_gated) begin
            if (bi || wri) begin
                m_gated     = 0;
                m_wake_left = WAKE;
            end
        end else if (m_wake_left > 0) begin
            m_wake_left = m_wake_left - 1;
            if (m_wake_left == 0) begin
                ack_now  = 1;
                m_streak = 0;
            end
        end else begin
            if (wri && !m_acked) ack_now = 1;
            if (bi || wri) begin
                m_streak = 0;
            end else begin
                m_streak = m_streak + 1;
                if (m_streak == IDLE + 1) begin
                    m_gated  = 1;
                    m_streak = 0;
                end
            end
        end
        m_acked = wri && (m_acked || ack_now);
        m_ack   = ack_now;
        ack0     = wri && !m0_acked;
        m0_acked = wri && (m0_acked || ack0);
        m0_ack   = ack0;
    endtask

    // One clock cycle: apply inputs, check outputs mid-cycle, advance model.
    task automatic cyc(input bit bi, input bit wri, input bit cci, input bit sei, input bit rsti);
        cyc_no++;
        b = bi; wr = wri; cc = cci; se = sei; rst = rsti;
        @(negedge clk);
        chk("enable",    32'(if1.ENABLE),   32'((!m_gated) || sei));
        chk("gated",     32'(if1.GATED),    32'(m_gated));
        chk("wake_ack",  32'(if1.WAKE_ACK), 32'(m_ack));
        chk("gate_cnt",  32'(if1.GATE_CNT), 32'(m_gcnt));
        chk("acg0_enable",   32'(if0.ENABLE),   32'(1));
        chk("acg0_gated",    32'(if0.GATED),    32'(0));
        chk("acg0_gate_cnt", 32'(if0.GATE_CNT), 32'(0));
        chk("acg0_wake_ack", 32'(if0.WAKE_ACK), 32'(m0_ack));
        last_en  = if1.ENABLE;
        last_ack = if1.WAKE_ACK;
        @(posedge clk);
        model_step(bi, wri, cci, rsti);
        #1;
    endtask

    initial begin
        int t0, first, saw_low, any_ack;
        bit rb, rwr, rse;

        // Power-up reset.
        b = 1; wr = 0; cc = 0; se = 0; rst = 1;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cyc(1, 0, 0, 0, 1);

        // Idle latency: BUSY drops, ENABLE must fall IDLE+1 cycles later.
        repeat (3) cyc(1, 0, 0, 0, 0);
        t0 = cyc_no + 1; first = -1;
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0, 0, 0);
            if (!last_en && first < 0) first = cyc_no;
        end
        chk("idle_latency", 32'(first - t0), 32'(IDLE + 1));

        // Short idle burst: never long enough to gate.
        repeat (6) cyc(1, 0, 0, 0, 0);
        saw_low = 0;
        for (int i = 0; i < 3; i++) begin cyc(0, 0, 0, 0, 0); if (!last_en) saw_low = 1; end
        for (int i = 0; i < 8; i++) begin cyc(1, 0, 0, 0, 0); if (!last_en) saw_low = 1; end
        chk("short_idle_no_gate", 32'(saw_low), 32'(0));

        // Wake request from gated: ack WAKE+1 cycles after request.
        repeat (10) cyc(0, 0, 0, 0, 0);
        t0 = cyc_no + 1; first = -1;
        for (int i = 0; i < 20 && first < 0; i++) begin
            cyc(0, 1, 0, 0, 0);
            if (last_ack) first = cyc_no;
        end
        chk("wake_latency", 32'(first - t0), 32'(WAKE + 1));
        repeat (3) cyc(0, 0, 0, 0, 0);

        // Wake request while running: ack on the next cycle.
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        chk("run_wake_ack", 32'(last_ack), 32'(1));
        cyc(1, 0, 0, 0, 0);

        // Scan enable while gated.
        repeat (10) cyc(0, 0, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 1, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);

        // Reset in the first WAKE cycle: abort, no acknowledge.
        repeat (4) cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        any_ack = 0;
        cyc(0, 0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin cyc(0, 0, 0, 0, 0); if (last_ack) any_ack = 1; end
        chk("rst_wake_no_ack", 32'(any_ack), 32'(0));

        // Randomized traffic.
        rb = 1; rwr = 0; rse = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0)  rb  = ~rb;
            if ($urandom_range(0, 19) == 0) rwr = ~rwr;
            if ($urandom_range(0, 29) == 0) rse = ~rse;
            cyc(rb, rwr, ($urandom_range(0, 49) == 0), rse, ($urandom_range(0, 499) == 0));
        end

        // Long gated stretch: counter saturates, then clears and resumes.
        for (int i = 0; i < 70000; i++) cyc(0, 0, 0, 0, 0);
        chk("gate_cnt_sat", 32'(if1.GATE_CNT), 32'(16'hFFFF));
        cyc(0, 0, 1, 0, 0);
        repeat (3) cyc(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
